// File: rtl/fire4_5_expand3_sched.sv
// Sequencer for the shared fire4/fire5 3x3 expand datapath.
// Runs fire4 expand3, acknowledges it, runs fire5 expand3, acknowledges it,
// and while each layer runs it streams the ifm read addresses for a 3x3,
// stride-1, pad-1 window in position-major, channel-minor tap order.
module fire4_5_expand3_sched #(
    parameter int WOUT       = 32,
    parameter int W_IN       = 32,
    parameter int CHIN       = 32,
    parameter int KERNEL_DIM = 3,
    parameter int PAD        = 1,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fire4_expand_3_finish,
    input  logic              fire5_expand_3_finish,
    output logic              fire4_expand_3_en,
    output logic              fire5_expand_3_en,
    output logic              ram_feedback_4,
    output logic              ram_feedback_5,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic              ifm_pad,
    output logic              ifm_valid,
    output logic              busy,
    output logic              done
);

    // Real taps per output pixel; index TAPS itself is the clear bubble.
    localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int KW   = $clog2(TAPS + 1);
    localparam int CW   = (WOUT > 1) ? $clog2(WOUT) : 1;
    localparam int SW   = $clog2(W_IN) + 2;

    typedef enum logic [2:0] {IDLE, RUN4, ACK4, RUN5, ACK5, DONE} state_t;

    state_t               state;
    logic [KW-1:0]        k, adv_k;
    logic [CW-1:0]        c, r, adv_c, adv_r;
    logic                 frozen, adv_frozen;
    logic                 running;
    int                   ch, pos, kr, kc;
    logic signed [SW-1:0] ir, ic;
    logic                 tap_valid, tap_pad;
    logic [ADDR_W-1:0]    tap_addr;

    assign running = (state == RUN4) || (state == RUN5);

    // Next position of the window walk; outside RUN it points at the first tap
    always_comb begin
        adv_k      = '0;
        adv_c      = '0;
        adv_r      = '0;
        adv_frozen = 1'b0;
        if (running) begin
            adv_k      = k;
            adv_c      = c;
            adv_r      = r;
            adv_frozen = frozen;
            if (!frozen) begin
                if (k == KW'(TAPS)) begin
                    if (c == CW'(WOUT - 1) && r == CW'(WOUT - 1)) begin
                        adv_frozen = 1'b1;
                    end else begin
                        adv_k = '0;
                        if (c == CW'(WOUT - 1)) begin
                            adv_c = '0;
                            adv_r = r + CW'(1);
                        end else begin
                            adv_c = c + CW'(1);
                        end
                    end
                end else begin
                    adv_k = k + KW'(1);
                end
            end
        end
    end

    // Decode the next tap into channel / window offset and the ifm address
    always_comb begin
        ch        = int'(adv_k) % CHIN;
        pos       = int'(adv_k) / CHIN;
        kr        = pos / KERNEL_DIM;
        kc        = pos % KERNEL_DIM;
        ir        = SW'(int'(adv_r) + kr - PAD);
        ic        = SW'(int'(adv_c) + kc - PAD);
        tap_valid = !adv_frozen && (adv_k != KW'(TAPS));
        tap_pad   = 1'b1;
        tap_addr  = '0;
        if (tap_valid) begin
            tap_pad = (ir < 0) || (int'(ir) >= W_IN) || (ic < 0) || (int'(ic) >= W_IN);
            if (!tap_pad) begin
                tap_addr = ADDR_W'(ch * W_IN * W_IN + int'(ir) * W_IN + int'(ic));
            end
        end
    end

    // Layer FSM with registered enables, acknowledges and address stream
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            k                 <= '0;
            c                 <= '0;
            r                 <= '0;
            frozen            <= 1'b0;
            fire4_expand_3_en <= 1'b0;
            fire5_expand_3_en <= 1'b0;
            ram_feedback_4    <= 1'b0;
            ram_feedback_5    <= 1'b0;
            ifm_addr          <= '0;
            ifm_pad           <= 1'b0;
            ifm_valid         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            k              <= adv_k;
            c              <= adv_c;
            r              <= adv_r;
            frozen         <= adv_frozen;
            ram_feedback_4 <= 1'b0;
            ram_feedback_5 <= 1'b0;
            ifm_addr       <= '0;
            ifm_pad        <= 1'b0;
            ifm_valid      <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state             <= RUN4;
                        fire4_expand_3_en <= 1'b1;
                        busy              <= 1'b1;
                        done              <= 1'b0;
                        ifm_addr          <= tap_addr;
                        ifm_pad           <= tap_pad;
                        ifm_valid         <= tap_valid;
                    end
                end
                RUN4: begin
                    if (fire4_expand_3_finish) begin
                        state             <= ACK4;
                        fire4_expand_3_en <= 1'b0;
                        ram_feedback_4    <= 1'b1;
                        k                 <= '0;
                        c                 <= '0;
                        r                 <= '0;
                        frozen            <= 1'b0;
                    end else begin
                        ifm_addr  <= tap_addr;
                        ifm_pad   <= tap_pad;
                        ifm_valid <= tap_valid;
                    end
                end
                ACK4: begin
                    state             <= RUN5;
                    fire5_expand_3_en <= 1'b1;
                    ifm_addr          <= tap_addr;
                    ifm_pad           <= tap_pad;
                    ifm_valid         <= tap_valid;
                end
                RUN5: begin
                    if (fire5_expand_3_finish) begin
                        state             <= ACK5;
                        fire5_expand_3_en <= 1'b0;
                        ram_feedback_5    <= 1'b1;
                        k                 <= '0;
                        c                 <= '0;
                        r                 <= '0;
                        frozen            <= 1'b0;
                    end else begin
                        ifm_addr  <= tap_addr;
                        ifm_pad   <= tap_pad;
                        ifm_valid <= tap_valid;
                    end
                end
                ACK5: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fire4_5_expand3_sched.sv
// Randomized bench for fire4_5_expand3_sched on a reduced 5x5x4 geometry,
// compared every cycle against an arithmetic model of the layer sequence.
module tb_fire4_5_expand3_sched;

    localparam int W    = 5;
    localparam int CH   = 4;
    localparam int KD   = 3;
    localparam int PADP = 1;
    localparam int AW   = 15;
    localparam int PER  = KD * KD * CH + 1;
    localparam int NPIX = W * W;

    logic          clk = 1'b0;
    logic          rst, start, f4, f5;
    logic          en4, en5, fb4, fb5, ifm_pad, ifm_valid, busy, done;
    logic [AW-1:0] ifm_addr;

    int checks   = 0;
    int failures = 0;
    int phase    = 0;
    int n        = 0;

    fire4_5_expand3_sched #(
        .WOUT(W), .W_IN(W), .CHIN(CH), .KERNEL_DIM(KD), .PAD(PADP), .ADDR_W(AW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .fire4_expand_3_finish (f4),
        .fire5_expand_3_finish (f5),
        .fire4_expand_3_en     (en4),
        .fire5_expand_3_en     (en5),
        .ram_feedback_4        (fb4),
        .ram_feedback_5        (fb5),
        .ifm_addr              (ifm_addr),
        .ifm_pad               (ifm_pad),
        .ifm_valid             (ifm_valid),
        .busy                  (busy),
        .done                  (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Phases: 0 idle, 1 fire4 run, 2 fire4 ack, 3 fire5 run, 4 fire5 ack, 5 done
    task automatic modelStep();
        if (rst) begin
            phase = 0;
            n     = 0;
        end else begin
            case (phase)
                0, 5: if (start) begin phase = 1; n = 0; end
                1: if (f4) phase = 2; else n++;
                2: begin phase = 3; n = 0; end
                3: if (f5) phase = 4; else n++;
                4: phase = 5;
                default: phase = 0;
            endcase
        end
    endtask

    task automatic compareAll();
        int tap, pix, row, col, chn, kr, kc, ir, ic;
        int e_valid, e_pad, e_addr;
        e_valid = 0;
        e_pad   = 0;
        e_addr  = 0;
        if (phase == 1 || phase == 3) begin
            tap = n % PER;
            pix = n / PER;
            if (pix >= NPIX || tap == PER - 1) begin
                e_pad = 1;
            end else begin
                e_valid = 1;
                row = pix / W;
                col = pix % W;
                chn = tap % CH;
                kr  = (tap / CH) / KD;
                kc  = (tap / CH) % KD;
                ir  = row + kr - PADP;
                ic  = col + kc - PADP;
                if (ir < 0 || ir >= W || ic < 0 || ic >= W) e_pad = 1;
                else e_addr = chn * W * W + ir * W + ic;
            end
        end
        checkOutput("fire4_en", 32'(en4), 32'(phase == 1));
        checkOutput("fire5_en", 32'(en5), 32'(phase == 3));
        checkOutput("ram_feedback_4", 32'(fb4), 32'(phase == 2));
        checkOutput("ram_feedback_5", 32'(fb5), 32'(phase == 4));
        checkOutput("busy", 32'(busy), 32'(phase >= 1 && phase <= 4));
        checkOutput("done", 32'(done), 32'(phase == 5));
        checkOutput("ifm_valid", 32'(ifm_valid), 32'(e_valid));
        checkOutput("ifm_pad", 32'(ifm_pad), 32'(e_pad));
        checkOutput("ifm_addr", 32'(ifm_addr), 32'(e_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelStep();
        compareAll();
    endtask

    task automatic applyStimulus(input int cycles, input bit rnd_start, input bit rnd_f4, input bit rnd_f5);
        for (int i = 0; i < cycles; i++) begin
            start = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            f4    = rnd_f4 ? 1'($urandom_range(0, 1)) : 1'b0;
            f5    = rnd_f5 ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
        f4    = 1'b0;
        f5    = 1'b0;
    endtask

    // Stimulus sequence
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        f4    = 1'b0;
        f5    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(5, 1'b0, 1'b1, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(NPIX * PER + 8, 1'b1, 1'b0, 1'b1);

        f4 = 1'b1;
        f5 = 1'b1;
        tick();
        f4 = 1'b0;
        f5 = 1'b0;
        applyStimulus(1 + $urandom_range(50, 300), 1'b1, 1'b1, 1'b0);

        f5 = 1'b1;
        tick();
        f5 = 1'b0;
        applyStimulus(6, 1'b0, 1'b1, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(PER * 3 + $urandom_range(0, PER), 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4, 1'b0, 1'b1, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus($urandom_range(5, 40), 1'b0, 1'b0, 1'b0);
        f4 = 1'b1;
        tick();
        f4 = 1'b0;
        applyStimulus(1 + NPIX * PER + 5, 1'b0, 1'b0, 1'b0);
        f5 = 1'b1;
        tick();
        f5 = 1'b0;
        applyStimulus(4, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
